// File: rtl/wire_rr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wire_arb_pkg
//  Purpose  : Shared types and index helpers for the round-robin wire arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package wire_arb_pkg;

   typedef enum logic {ST_IDLE, ST_LOCK} arb_state_e;

   // Index helpers carry 3 bits, enough for the largest legal N of 8.
   localparam int C_IDX_W = 3;

   function automatic logic [C_IDX_W-1:0] next_idx(input logic [C_IDX_W-1:0] idx,
                                                   input int n);
      if (int'(idx) >= n - 1) begin
         return '0;
      end
      return idx + 3'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wire_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : wire_rr_arbiter_if
//  Purpose  : Requester streams plus the shared registered output bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface wire_rr_arbiter_if #(
   parameter int N = 3,
   parameter int W = 8
);
   logic [N-1:0]         req_valid;
   logic [N*W-1:0]       req_data;
   logic [N-1:0]         req_last;
   logic [N-1:0]         req_ready;
   logic                 out_valid;
   logic [W-1:0]         out_data;
   logic                 out_last;
   logic [$clog2(N)-1:0] out_src;
   logic                 out_ready;

   // Arbiter side
   modport slave (
      input  req_valid, req_data, req_last, out_ready,
      output req_ready, out_valid, out_data, out_last, out_src
   );

   // Requester / downstream side
   modport master (
      output req_valid, req_data, req_last, out_ready,
      input  req_ready, out_valid, out_data, out_last, out_src
   );
endinterface
`default_nettype wire

// File: rtl/wire_rr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational rotate-priority picker starting at i_ptr.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_picker
   import wire_arb_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic                 o_found,
   output logic [$clog2(N)-1:0] o_idx
);
   localparam int C_IW = $clog2(N);

   logic [C_IW-1:0] w_cand;
   logic            w_hit;
   logic [C_IW-1:0] w_idx;

   always_comb begin
      w_hit  = 1'b0;
      w_idx  = '0;
      w_cand = i_ptr;
      for (int k = 0; k < N; k++) begin
         if (!w_hit && i_req[w_cand]) begin
            w_hit = 1'b1;
            w_idx = w_cand;
         end
         w_cand = C_IW'(next_idx(C_IDX_W'(w_cand), N));
      end
   end

   assign o_found = w_hit;
   assign o_idx   = w_idx;

endmodule
`default_nettype wire

// File: rtl/wire_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wire_rr_arbiter
//  Purpose  : Round-robin arbiter driving one registered output bundle from N
//             valid/ready requesters; multi-beat bursts hold the grant.
//  Revision : 1.0 - initial release
// ============================================================================
module wire_rr_arbiter
   import wire_arb_pkg::*;
#(
   parameter int N = 3,
   parameter int W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   wire_rr_arbiter_if.slave    bus
);
   localparam int C_IW = $clog2(N);

   arb_state_e      r_state;
   arb_state_e      w_state_nxt;
   logic [C_IW-1:0] r_rr_ptr;
   logic [C_IW-1:0] w_ptr_nxt;
   logic [C_IW-1:0] r_owner;
   logic [C_IW-1:0] w_owner_nxt;

   logic            r_out_valid;
   logic [W-1:0]    r_out_data;
   logic            r_out_last;
   logic [C_IW-1:0] r_out_src;

   logic            w_can_load;
   logic            w_found;
   logic [C_IW-1:0] w_pick;
   logic [C_IW-1:0] w_sel;
   logic            w_load;
   logic [N-1:0]    w_ready;

   rr_picker #(.N(N)) u_picker (
      .i_req   (bus.req_valid),
      .i_ptr   (r_rr_ptr),
      .o_found (w_found),
      .o_idx   (w_pick)
   );

   assign w_can_load = !r_out_valid || bus.out_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_rr_ptr;
      w_owner_nxt = r_owner;
      w_sel       = r_owner;
      w_load      = 1'b0;
      w_ready     = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_found && w_can_load) begin
               w_sel           = w_pick;
               w_load          = 1'b1;
               w_ready[w_pick] = 1'b1;
               if (bus.req_last[w_pick]) begin
                  w_ptr_nxt = C_IW'(next_idx(C_IDX_W'(w_pick), N));
               end else begin
                  w_owner_nxt = w_pick;
                  w_state_nxt = ST_LOCK;
               end
            end
         end
         ST_LOCK: begin
            // Only the burst owner may move; a gap in its valid idles the bus.
            if (bus.req_valid[r_owner] && w_can_load) begin
               w_load           = 1'b1;
               w_ready[r_owner] = 1'b1;
               if (bus.req_last[r_owner]) begin
                  w_state_nxt = ST_IDLE;
                  w_ptr_nxt   = C_IW'(next_idx(C_IDX_W'(r_owner), N));
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_rr_ptr    <= '0;
         r_owner     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_src   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_rr_ptr <= w_ptr_nxt;
         r_owner  <= w_owner_nxt;
         if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= bus.req_data[int'(w_sel)*W +: W];
            r_out_last  <= bus.req_last[w_sel];
            r_out_src   <= w_sel;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // Nothing may be accepted while reset is held, even though the register is empty.
   assign bus.req_ready = w_ready & {N{rst_n}};
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign bus.out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_wire_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wire_rr_arbiter
//  Purpose  : Directed table-driven bench for wire_rr_arbiter (N=3, W=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wire_rr_arbiter;
   localparam int N = 3;
   localparam int W = 8;
   localparam int NV = 24;

   typedef struct {
      logic [2:0] v;
      logic [2:0] l;
      logic       ordy;
      logic [2:0] e_rdy;
      logic       e_ov;
      logic [1:0] e_src;
      logic       e_last;
      logic [7:0] e_data;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;
   vec_t vecs [NV];

   wire_rr_arbiter_if #(.N(N), .W(W)) bus ();

   wire_rr_arbiter #(.N(N), .W(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [2:0] v, input logic [2:0] l, input logic ordy,
                               input logic [2:0] e_rdy, input logic e_ov, input logic [1:0] e_src,
                               input logic e_last, input logic [7:0] e_data);
      vec_t r;
      r.v = v; r.l = l; r.ordy = ordy; r.e_rdy = e_rdy;
      r.e_ov = e_ov; r.e_src = e_src; r.e_last = e_last; r.e_data = e_data;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] v, input logic [2:0] l, input logic ordy,
                        input logic [3:0] tag);
      bus.req_valid = v;
      bus.req_last  = l;
      bus.out_ready = ordy;
      bus.req_data  = {4'd2, tag, 4'd1, tag, 4'd0, tag};
   endtask

   task automatic check_out(input string name, input logic ov, input logic [1:0] src,
                            input logic last, input logic [7:0] data);
      check(name, {20'd0, bus.out_valid, bus.out_src, bus.out_last, bus.out_data},
            {20'd0, ov, src, last, data});
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;

      // fairness: single-beat bursts from everyone
      vecs[0]  = mk(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1, 8'h00);
      vecs[1]  = mk(3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1, 8'h11);
      vecs[2]  = mk(3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1, 8'h22);
      vecs[3]  = mk(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1, 8'h03);
      vecs[4]  = mk(3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1, 8'h14);
      vecs[5]  = mk(3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1, 8'h25);
      // requester 1 four-beat burst while 0 and 2 wait
      vecs[6]  = mk(3'b010, 3'b000, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0, 8'h16);
      vecs[7]  = mk(3'b111, 3'b101, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0, 8'h17);
      vecs[8]  = mk(3'b111, 3'b101, 1'b1, 3'b010, 1'b1, 2'd1, 1'b0, 8'h18);
      vecs[9]  = mk(3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1, 8'h19);
      vecs[10] = mk(3'b111, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1, 8'h2A);
      vecs[11] = mk(3'b111, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1, 8'h0B);
      // backpressure for three cycles, then drain and load together
      vecs[12] = mk(3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1, 8'h0B);
      vecs[13] = mk(3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1, 8'h0B);
      vecs[14] = mk(3'b111, 3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 1'b1, 8'h0B);
      vecs[15] = mk(3'b111, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 1'b1, 8'h1F);
      // drain to empty, data fields hold
      vecs[16] = mk(3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd1, 1'b1, 8'h1F);
      vecs[17] = mk(3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 2'd1, 1'b1, 8'h1F);
      // requester 2 burst with a valid gap while 0 waits
      vecs[18] = mk(3'b101, 3'b000, 1'b1, 3'b100, 1'b1, 2'd2, 1'b0, 8'h22);
      vecs[19] = mk(3'b101, 3'b000, 1'b1, 3'b100, 1'b1, 2'd2, 1'b0, 8'h23);
      vecs[20] = mk(3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 2'd2, 1'b0, 8'h23);
      vecs[21] = mk(3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 2'd2, 1'b0, 8'h23);
      vecs[22] = mk(3'b101, 3'b100, 1'b1, 3'b100, 1'b1, 2'd2, 1'b1, 8'h26);
      vecs[23] = mk(3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 1'b1, 8'h07);

      // reset held with every requester active
      rst_n = 1'b0;
      drive(3'b111, 3'b111, 1'b1, 4'h0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", {29'd0, bus.req_ready}, 32'd0);
      check_out("reset_out", 1'b0, 2'd0, 1'b0, 8'h00);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].v, vecs[i].l, vecs[i].ordy, 4'(i));
         #2;
         check($sformatf("v%0d_ready", i), {29'd0, bus.req_ready}, {29'd0, vecs[i].e_rdy});
         @(posedge clk);
         #1;
         check_out($sformatf("v%0d_out", i), vecs[i].e_ov, vecs[i].e_src,
                   vecs[i].e_last, vecs[i].e_data);
      end

      // enter a requester-1 burst, then reset between edges
      drive(3'b010, 3'b000, 1'b1, 4'hE);
      #2;
      check("lock_ready", {29'd0, bus.req_ready}, 32'b010);
      @(posedge clk);
      #1;
      check_out("lock_out", 1'b1, 2'd1, 1'b0, 8'h1E);
      #3;
      rst_n = 1'b0;
      #1;
      check_out("async_rst_out", 1'b0, 2'd0, 1'b0, 8'h00);
      check("async_rst_ready", {29'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(3'b111, 3'b111, 1'b1, 4'hE);
      #2;
      check("post_rst_ready", {29'd0, bus.req_ready}, 32'b001);
      @(posedge clk);
      #1;
      check_out("post_rst_out", 1'b1, 2'd0, 1'b1, 8'h0E);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wire_rr_arbiter.md
# wire_rr_arbiter

Round-robin arbiter that shares one registered output wire bundle among N requesters, each presenting a valid/ready stream of W-bit beats with a last flag. It sits ahead of the fan-out wiring blocks, deciding which source drives the shared bus each cycle. Multi-beat bursts hold the grant until the burst's last beat. Fairness is by rotating priority.

## Interface
- N, default 3: number of requesters (2..8).
- W, default 8: beat data width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester beat valid.
- req_data  in  N*W  requester i occupies bits [i*W +: W].
- req_last  in  N  per-requester last-beat-of-burst flag.
- req_ready  out  N  per-requester accept; combinational from state, pointer, req_valid and out_ready.
- out_valid  out  1  registered output beat valid.
- out_data  out  W  registered output beat data.
- out_last  out  1  registered copy of the accepted beat's last flag.
- out_src  out  $clog2(N)  index of the requester that supplied the output beat.
- out_ready  in  1  downstream accept.

## Operation
- Reset: state IDLE; rr_ptr = 0; owner = 0; out_valid = 0; out_data = 0; out_last = 0; out_src = 0.
- can_load = !out_valid || out_ready. A beat transfers from requester i when req_valid[i] && req_ready[i].
- At most one req_ready bit is high in any cycle, and only when can_load = 1.
- IDLE:
  - Pick the first requester with req_valid set, scanning rr_ptr, rr_ptr+1, … mod N.
  - If can_load, assert req_ready for the picked requester and load the output register.
  - If the accepted beat has req_last = 1, stay in IDLE and set rr_ptr = (picked+1) mod N.
  - Otherwise set owner = picked and go to LOCK.
  - With no requester valid, nothing changes.
- LOCK:
  - Only req_ready[owner] may be asserted, and only when can_load.
  - Other requesters' valid beats wait regardless of their priority.
  - When an accepted beat has req_last = 1, go to IDLE and set rr_ptr = (owner+1) mod N.
  - If req_valid[owner] drops mid-burst, the lock holds and the bus idles.
- Output register:
  - On a load: out_data, out_last and out_src take the beat's values, and out_valid = 1.
  - Else if out_ready: out_valid = 0. Data fields keep their last value.
  - Otherwise everything holds.
- rr_ptr wraps from N-1 to 0. Index arithmetic is done in $clog2(N) bits with an explicit compare against N, so non-power-of-two N is legal.
- Async reset mid-burst drops the lock and any pending output beat. Requesters must resend after reset.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is on out_* after edge k.
- Throughput is one beat per cycle while out_ready stays high, including back-to-back beats from different requesters in IDLE.
- out_ready = 0 with out_valid = 1 stalls all requesters; out_* hold stable.
- Simultaneous drain and load in one cycle is allowed: the output register is overwritten and out_valid stays 1.
- A single-beat burst (last on the first beat) never enters LOCK.

## Structure
- Package wire_arb_pkg holds:
  - typedef enum logic {ST_IDLE, ST_LOCK} arb_state_e;
  - the function next_idx(idx, n) for mod-N increment.
- Sub-module rr_picker (N): combinational rotate-priority picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: found flag and index.
- The top level holds the FSM, rr_ptr, owner and the output register.

## Test plan
- Reset: hold rst_n = 0 with requests active → all outputs 0 and req_ready = 0. Release → first grant goes to requester 0.
- Fairness, N=3, all requesters valid with single-beat bursts, out_ready = 1 → out_src sequence is 0,1,2,0,1,2 with one beat per cycle.
- Burst lock: requester 1 sends 4 beats (last on the 4th) while 0 and 2 are valid → out_src = 1,1,1,1, then 2, then 0.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 → out_* stable and req_ready all 0. Raise out_ready → beat drains and the next beat loads in the same cycle.
- Owner gap: requester 2 drops valid after beat 2 of a 3-beat burst while 0 is valid → no beat from 0 until requester 2 sends its last beat.
- Async reset mid-burst: assert rst_n = 0 between clock edges during a LOCK → out_valid falls immediately, and the next grant follows rr_ptr = 0.
